mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single processor-to-memory bus between the instruction cache (demand fetches and prefetches) and the data cache. Each cycle it grants the one-command-per-cycle memory port to at most one requester and returns the memory's acceptance tag to that requester only. It records which requester owns each outstanding load tag, so each returning data beat is delivered only to its owner. It sits between the fetch-side icache, the LSQ-side dcache, and the top-level memory ports.

## Interface

- STARVE_LIMIT, default 4: consecutive dcache wins tolerated while the icache waits (fairness build only).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- proc2Imem_command  in  2  icache command: BUS_NONE or BUS_LOAD.
- proc2Imem_addr  in  XLEN  icache address, 8-byte aligned.
- Imem2proc_response  out  4  acceptance tag for an icache command; 0 means not accepted.
- Imem2proc_data  out  64  copy of mem2proc_data.
- Imem2proc_tag  out  4  mem2proc_tag when the returning tag is owned by the icache, else 0.
- proc2Dmem_command  in  2  dcache command: BUS_NONE, BUS_LOAD or BUS_STORE.
- proc2Dmem_addr  in  XLEN  dcache address.
- proc2Dmem_data  in  64  store data.
- Dmem2proc_response  out  4  acceptance tag for a dcache command; 0 means not accepted.
- Dmem2proc_data  out  64  copy of mem2proc_data.
- Dmem2proc_tag  out  4  mem2proc_tag when the returning tag is owned by the dcache, else 0.
- proc2mem_command  out  2  command forwarded to memory.
- proc2mem_addr  out  XLEN  address forwarded to memory.
- proc2mem_data  out  64  store data forwarded to memory.
- mem2proc_response  in  4  memory acceptance tag; 0 means rejected.
- mem2proc_data  in  64  returning data.
- mem2proc_tag  in  4  tag of returning data; 0 means no return this cycle.

## Operation

**Grant (combinational, same cycle)**
- Only the dcache requests: dcache granted.
- Only the icache requests: icache granted.
- Both request: dcache granted, unless the fairness override is active (see Configuration).
- Nobody requests: proc2mem_command = BUS_NONE, proc2mem_addr = 0, proc2mem_data = 0.

**Forwarding and response**
- The granted requester's command, address and (for dcache) data drive the proc2mem_* outputs.
- mem2proc_response is routed to the granted requester's response port.
- The non-granted requester's response port is 0, so it retries the next cycle.

**Owner table**
- 15 entries, indexed by tags 1..15.
- Each entry holds a valid bit and an owner bit: 0 = icache, 1 = dcache.
- At a clock edge, an accepted BUS_LOAD (granted and mem2proc_response ≠ 0) sets entry[mem2proc_response] to valid, with the grantee as owner.
- BUS_STORE never allocates an entry.

**Return routing**
- When mem2proc_tag ≠ 0 and entry[mem2proc_tag] is valid, the tag is driven to the owner's *mem2proc_tag port.
- The other requester's tag port is 0.
- At the same clock edge, that entry is cleared.
- A return on an invalid entry is delivered to neither requester; this is an illegal condition.
- Data ports always mirror mem2proc_data.

**Boundary cases**
- Same tag returned and re-issued in one cycle: routing uses the registered (old) owner; the entry is then set to the new owner, because set has priority over clear.
- Squash on the fetch side: no effect. Entries stay until memory returns the tag; the icache discards unmatched tags itself.
- Reset asserted mid-transaction: table cleared immediately. Returns for pre-reset tags are then delivered to neither requester.

## Timing

**Latency**
- Request to memory: 0 cycles (combinational path).
- Acceptance tag back to the requester: same cycle.
- Tag routing: combinational from mem2proc_tag plus the registered table.

**State**
- Registers: owner table (15 × 2 bits) and the starvation counter.
- While reset is low:
  - all table entries are invalid and the counter is 0;
  - outputs are forced to their idle values: proc2mem_command = BUS_NONE, all *_response = 0, all *_tag = 0, all addresses and data = 0.
- First possible grant: the cycle reset deasserts.

## Configuration

- MEM_ARB_FAIRNESS_EN
- **Defined:** a 3-bit starvation counter is present.
  - Increments at each edge where both requesters request and the dcache is granted.
  - Saturates at STARVE_LIMIT.
  - Cleared at any edge where the icache is granted.
  - When the counter equals STARVE_LIMIT, a two-way conflict goes to the icache.
- **Undefined:** strict dcache priority; no counter exists.

## Test plan

- **Icache alone:** icache BUS_LOAD 0x100, memory responds 3 → Imem2proc_response = 3, Dmem2proc_response = 0. Later mem2proc_tag = 3 → Imem2proc_tag = 3, Dmem2proc_tag = 0, entry 3 cleared.
- **Conflict:** icache load and dcache load in the same cycle, memory responds 5 → dcache gets 5, icache gets 0, proc2mem_addr equals the dcache address.
- **Fairness (MEM_ARB_FAIRNESS_EN defined, STARVE_LIMIT = 4):** both request continuously → dcache granted cycles 1–4, icache granted cycle 5, dcache again cycle 6. Without the macro → dcache granted every cycle.
- **Store:** dcache BUS_STORE, memory responds 7 → Dmem2proc_response = 7, no entry allocated. A later mem2proc_tag = 7 → both tag outputs are 0.
- **Tag reuse:** entry 2 owned by icache; in one cycle mem2proc_tag = 2 and a dcache load is accepted with response 2 → Imem2proc_tag = 2 that cycle. The next return of tag 2 goes to the dcache.
- **Reset mid-operation:** tags 1 and 4 outstanding; pulse reset low → all outputs idle during reset. Afterwards mem2proc_tag = 4 → both tag outputs are 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single processor-to-memory command port between
// the icache and the dcache. The grant and acceptance-tag return are
// combinational (same cycle). A 15-entry owner table remembers which requester
// issued each outstanding load tag, so returning data beats are tagged only
// toward their owner.
//
// Optional build macro: MEM_ARB_FAIRNESS_EN adds a 3-bit starvation counter
// that hands a two-way conflict to the icache after STARVE_LIMIT consecutive
// dcache wins. Without it the dcache always wins a conflict.
//
// Ports:
//   clock, reset (async, active-low)
//   proc2Imem_command/addr         icache request (BUS_NONE or BUS_LOAD)
//   Imem2proc_response/data/tag    icache acceptance tag, data mirror, owned return tag
//   proc2Dmem_command/addr/data    dcache request (BUS_NONE, BUS_LOAD, BUS_STORE)
//   Dmem2proc_response/data/tag    dcache acceptance tag, data mirror, owned return tag
//   proc2mem_command/addr/data     forwarded command toward memory
//   mem2proc_response/data/tag     memory acceptance tag, return data, return tag
module mem_bus_arbiter #(
  parameter int unsigned XLEN = 32
`ifdef MEM_ARB_FAIRNESS_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag
);

  // Bus command encodings (BUS_STORE = 2'd2 needs no explicit decode here).
  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;
  localparam int unsigned NUM_TAGS = 16;

  logic                i_req;
  logic                d_req;
  logic                fair_override;
  logic                grant_i;
  logic                grant_d;
  logic                alloc;
  logic                ret_hit;
  // Index 0 is the "no tag" encoding and is never set.
  logic [NUM_TAGS-1:0] valid_q;
  logic [NUM_TAGS-1:0] valid_nxt;
  logic [NUM_TAGS-1:0] owner_q;   // 0 = icache, 1 = dcache
  logic [NUM_TAGS-1:0] owner_nxt;

  // Request decode and fixed-priority grant with optional fairness override.
  assign i_req   = (proc2Imem_command != BUS_NONE);
  assign d_req   = (proc2Dmem_command != BUS_NONE);
  assign grant_d = d_req && !(i_req && fair_override);
  assign grant_i = i_req && !grant_d;

  // A load accepted by memory allocates the returned tag to the grantee.
  assign alloc = reset && (mem2proc_response != 4'd0) &&
                 ((grant_d && (proc2Dmem_command == BUS_LOAD)) ||
                  (grant_i && (proc2Imem_command == BUS_LOAD)));

  assign ret_hit = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  logic [2:0] starve_q;

  assign fair_override = (starve_q == STARVE_MAX);

  // Counts consecutive conflict losses by the icache; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (grant_i) begin
      starve_q <= '0;
    end else if (i_req && grant_d && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 3'd1;
    end
  end
`else
  assign fair_override = 1'b0;
`endif

  // Owner table next state: a return clears its entry, allocation wins over clear.
  always_comb begin
    valid_nxt = valid_q;
    owner_nxt = owner_q;
    if (ret_hit) begin
      valid_nxt[mem2proc_tag] = 1'b0;
    end
    if (alloc) begin
      valid_nxt[mem2proc_response] = 1'b1;
      owner_nxt[mem2proc_response] = grant_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      owner_q <= owner_nxt;
    end
  end

  // Forwarding, response routing and return-tag routing; all idle in reset.
  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    Imem2proc_data     = '0;
    Dmem2proc_data     = '0;
    Imem2proc_tag      = '0;
    Dmem2proc_tag      = '0;
    if (reset) begin
      Imem2proc_data = mem2proc_data;
      Dmem2proc_data = mem2proc_data;
      if (grant_d) begin
        proc2mem_command   = proc2Dmem_command;
        proc2mem_addr      = proc2Dmem_addr;
        proc2mem_data      = proc2Dmem_data;
        Dmem2proc_response = mem2proc_response;
      end else if (grant_i) begin
        proc2mem_command   = proc2Imem_command;
        proc2mem_addr      = proc2Imem_addr;
        Imem2proc_response = mem2proc_response;
      end
      if (ret_hit) begin
        if (owner_q[mem2proc_tag]) begin
          Dmem2proc_tag = mem2proc_tag;
        end else begin
          Imem2proc_tag = mem2proc_tag;
        end
      end
    end
  end

endmodule
